// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the memory bridge.
//   state_t  : bridge FSM state encoding
//   SIZE_*   : funct3 access-size codes (sign/zero variants share a width)
//   BE_W     : byte-enable width of the memory bus
//   access_t : decoded access width, see size_of()
package mem_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      WRITE_WAIT,
      RESPOND
   } state_t;

   localparam logic [2:0] SIZE_B  = 3'b000;
   localparam logic [2:0] SIZE_H  = 3'b001;
   localparam logic [2:0] SIZE_W  = 3'b010;
   localparam logic [2:0] SIZE_BU = 3'b100;
   localparam logic [2:0] SIZE_HU = 3'b101;

   localparam int BE_W = 4;

   typedef enum logic [1:0] {
      ACC_B,
      ACC_H,
      ACC_W
   } access_t;

   // Unlisted funct3 codes are treated as word accesses.
   function automatic access_t size_of(input logic [2:0] funct3);
      case (funct3)
         SIZE_B, SIZE_BU: size_of = ACC_B;
         SIZE_H, SIZE_HU: size_of = ACC_H;
         default:         size_of = ACC_W;
      endcase
   endfunction

endpackage

// File: rtl/memory_bridge_if.sv
// Word-addressed memory bus between the bridge and the memory.
//   mem_req   : request, held until mem_ack
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word address ([1:0] = 00)
//   mem_be    : byte enables, bit i = lane i
//   mem_wdata : store data on the addressed lanes
//   mem_ack   : one-cycle acknowledge
//   mem_rdata : read data, valid with mem_ack
interface memory_bridge_if;
   logic                          mem_req;
   logic                          mem_we;
   logic [31:0]                   mem_addr;
   logic [mem_bridge_pkg::BE_W-1:0] mem_be;
   logic [31:0]                   mem_wdata;
   logic                          mem_ack;
   logic [31:0]                   mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/byte_lane_align.sv
// Combinational lane steering for sub-word accesses.
//   funct3        : access size code
//   addr_lo       : byte offset within the word
//   wdata         : right-justified store data
//   rdata         : word read data from memory
//   be            : byte enables for the access
//   wdata_lanes   : store data replicated onto the lanes
//   rdata_aligned : addressed bytes shifted to the LSBs, zero-filled
//   misaligned    : access does not sit on its natural boundary
module byte_lane_align
   import mem_bridge_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [31:0]     wdata,
   input  logic [31:0]     rdata,
   output logic [BE_W-1:0] be,
   output logic [31:0]     wdata_lanes,
   output logic [31:0]     rdata_aligned,
   output logic            misaligned
);

   logic [31:0] shifted;

   always_comb begin
      shifted       = rdata >> {addr_lo, 3'b000};
      be            = 4'b1111;
      wdata_lanes   = wdata;
      rdata_aligned = rdata;
      misaligned    = 1'b0;
      case (size_of(funct3))
         ACC_B: begin
            be            = 4'b0001 << addr_lo;
            wdata_lanes   = {4{wdata[7:0]}};
            rdata_aligned = {24'b0, shifted[7:0]};
         end
         ACC_H: begin
            // Offset 3 would spill off the mask, but it is rejected as misaligned.
            be            = 4'b0011 << addr_lo;
            wdata_lanes   = {2{wdata[15:0]}};
            rdata_aligned = {16'b0, shifted[15:0]};
            misaligned    = addr_lo[0];
         end
         default: begin
            misaligned    = (addr_lo != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/memory_bridge.sv
// Bridges single load/store requests onto a word-addressed memory bus
// with byte enables, a bounded wait for mem_ack and alignment checking.
//   clk, reset        : clock, synchronous active-high reset
//   req_read_en       : one-cycle pulse, start a load
//   req_write_en      : one-cycle pulse, start a store (wins over a load)
//   req_read_address  : load byte address
//   req_write_address : store byte address
//   req_write_data    : right-justified store data
//   req_funct3        : access size
//   read_value        : last completed load, zero-extended
//   busy              : transaction in flight
//   done              : one-cycle completion pulse
//   misaligned        : with done, access rejected for alignment
//   timeout           : with done, memory never acknowledged
//   mem               : memory bus (master side)
//
// state      | meaning
// IDLE       | waiting for a request
// READ_WAIT  | load issued, waiting for mem_ack or timeout
// WRITE_WAIT | store issued, waiting for mem_ack or timeout
// RESPOND    | result settled; emits done on the way back to IDLE
module memory_bridge
   import mem_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_read_en,
   input  logic                 req_write_en,
   input  logic [31:0]          req_read_address,
   input  logic [31:0]          req_write_address,
   input  logic [31:0]          req_write_data,
   input  logic [2:0]           req_funct3,
   output logic [31:0]          read_value,
   output logic                 busy,
   output logic                 done,
   output logic                 misaligned,
   output logic                 timeout,
   memory_bridge_if.master      mem
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // Down-counter loaded on issue; terminal count 0 marks the last wait cycle.
   localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT_CYCLES - 1);

   state_t          state;
   logic [2:0]      funct3_q;
   logic [1:0]      addr_lo_q;
   logic [CW-1:0]   wait_cnt;
   logic            pend_mis;
   logic            pend_to;

   logic [31:0]     req_addr;
   logic [2:0]      sel_funct3;
   logic [1:0]      sel_addr_lo;
   logic [BE_W-1:0] lane_be;
   logic [31:0]     lane_wdata;
   logic [31:0]     lane_rdata;
   logic            lane_mis;

   assign req_addr = req_write_en ? req_write_address : req_read_address;

   // One aligner serves both directions: in IDLE it sees the incoming
   // request, afterwards the captured size/offset for read-data alignment.
   assign sel_funct3  = (state == IDLE) ? req_funct3    : funct3_q;
   assign sel_addr_lo = (state == IDLE) ? req_addr[1:0] : addr_lo_q;

   byte_lane_align u_align (
      .funct3        (sel_funct3),
      .addr_lo       (sel_addr_lo),
      .wdata         (req_write_data),
      .rdata         (mem.mem_rdata),
      .be            (lane_be),
      .wdata_lanes   (lane_wdata),
      .rdata_aligned (lane_rdata),
      .misaligned    (lane_mis)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         funct3_q      <= '0;
         addr_lo_q     <= '0;
         wait_cnt      <= '0;
         pend_mis      <= 1'b0;
         pend_to       <= 1'b0;
         read_value    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         misaligned    <= 1'b0;
         timeout       <= 1'b0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_be    <= '0;
         mem.mem_wdata <= '0;
      end else begin
         done       <= 1'b0;
         misaligned <= 1'b0;
         timeout    <= 1'b0;
         case (state)
            IDLE: begin
               if (req_read_en || req_write_en) begin
                  funct3_q  <= req_funct3;
                  addr_lo_q <= req_addr[1:0];
                  pend_mis  <= lane_mis;
                  pend_to   <= 1'b0;
                  busy      <= 1'b1;
                  if (lane_mis) begin
                     state <= RESPOND;
                  end else begin
                     mem.mem_req   <= 1'b1;
                     mem.mem_we    <= req_write_en;
                     mem.mem_addr  <= {req_addr[31:2], 2'b00};
                     mem.mem_be    <= lane_be;
                     mem.mem_wdata <= lane_wdata;
                     wait_cnt      <= WAIT_LOAD;
                     state         <= req_write_en ? WRITE_WAIT : READ_WAIT;
                  end
               end
            end
            READ_WAIT, WRITE_WAIT: begin
               // Ack takes priority over an expiring counter.
               if (mem.mem_ack) begin
                  mem.mem_req <= 1'b0;
                  if (state == READ_WAIT) read_value <= lane_rdata;
                  state <= RESPOND;
               end else if (wait_cnt == '0) begin
                  mem.mem_req <= 1'b0;
                  pend_to     <= 1'b1;
                  state       <= RESPOND;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESPOND: begin
               done       <= 1'b1;
               misaligned <= pend_mis;
               timeout    <= pend_to;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_bridge.sv
// Bench for memory_bridge: directed vector table, mid-wait reset sequence,
// then randomized transactions checked against an arithmetic model.
module tb_memory_bridge;
   import mem_bridge_pkg::*;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_read_en, req_write_en;
   logic [31:0] req_read_address, req_write_address, req_write_data;
   logic [2:0]  req_funct3;
   logic [31:0] read_value;
   logic        busy, done, misaligned, timeout;

   memory_bridge_if bus();

   memory_bridge #(.TIMEOUT_CYCLES(T)) dut (
      .clk               (clk),
      .reset             (reset),
      .req_read_en       (req_read_en),
      .req_write_en      (req_write_en),
      .req_read_address  (req_read_address),
      .req_write_address (req_write_address),
      .req_write_data    (req_write_data),
      .req_funct3        (req_funct3),
      .read_value        (read_value),
      .busy              (busy),
      .done              (done),
      .misaligned        (misaligned),
      .timeout           (timeout),
      .mem               (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] raddr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      int          delay;       // mem_req cycle index that gets the ack
      logic [31:0] rdata;
      logic        poke;        // extra load pulse while busy
      int          exp_req_cycles;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      int          exp_done;    // cycle of done, request cycle = 0
      logic        exp_mis;
      logic        exp_to;
      logic [31:0] exp_rv;
   } vec_t;

   vec_t        tbl[13];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        stray_en = 1'b0;
   logic [31:0] model_rv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_ack();
      bus.mem_ack   = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_rdata = $urandom;
   endtask

   // Expected behaviour from access rules: natural alignment, lane
   // replication and byte extraction expressed as plain arithmetic.
   function automatic vec_t model(input vec_t v, input logic [31:0] prev_rv);
      logic [31:0] a;
      int          n, off;
      logic [63:0] lane, acc;
      a = v.wr ? v.waddr : v.raddr;
      off = int'(a % 4);
      case (v.f3)
         3'b000, 3'b100: n = 1;
         3'b001, 3'b101: n = 2;
         default:        n = 4;
      endcase
      lane = 64'(v.wdata) % (64'd1 << (8 * n));
      acc  = 0;
      for (int k = 0; k < 4 / n; k++) acc = acc + (lane << (8 * n * k));
      v.exp_we    = v.wr;
      v.exp_addr  = a - 32'(off);
      v.exp_be    = 4'(((1 << n) - 1) << off);
      v.exp_wdata = acc[31:0];
      v.exp_mis   = (a % n) != 0;
      v.exp_to    = 1'b0;
      v.exp_rv    = prev_rv;
      if (v.exp_mis) begin
         v.exp_req_cycles = 0;
         v.exp_done       = 2;
      end else if (v.delay < T) begin
         v.exp_req_cycles = v.delay + 1;
         v.exp_done       = 3 + v.delay;
         if (!v.wr) v.exp_rv = 32'((64'(v.rdata) >> (8 * off)) % (64'd1 << (8 * n)));
      end else begin
         v.exp_req_cycles = T;
         v.exp_done       = T + 2;
         v.exp_to         = 1'b1;
      end
      return v;
   endfunction

   task automatic apply(input vec_t v, input string name);
      int          req_cnt  = 0;
      int          done_cyc = -1;
      logic        stable   = 1'b1;
      logic        quiet    = 1'b1;
      logic        busy1    = 1'b0;
      logic        busy_d   = 1'b1;
      logic        mis_d    = 1'b0;
      logic        to_d     = 1'b0;
      logic [31:0] rv_d     = '0;
      logic        cap_we   = 1'b0;
      logic [31:0] cap_addr = '0;
      logic [3:0]  cap_be   = '0;
      logic [31:0] cap_wd   = '0;

      req_read_en       = v.rd;
      req_write_en      = v.wr;
      req_read_address  = v.raddr;
      req_write_address = v.waddr;
      req_write_data    = v.wdata;
      req_funct3        = v.f3;
      idle_ack();
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            req_write_en     = 1'b0;
            req_read_en      = v.poke;
            req_read_address = 32'h20;
            busy1            = busy;
         end else begin
            req_read_en = 1'b0;
         end
         if (done) begin
            done_cyc = c;
            mis_d    = misaligned;
            to_d     = timeout;
            rv_d     = read_value;
            busy_d   = busy;
         end
         if (bus.mem_req) begin
            if (req_cnt == 0) begin
               cap_we   = bus.mem_we;
               cap_addr = bus.mem_addr;
               cap_be   = bus.mem_be;
               cap_wd   = bus.mem_wdata;
            end else if (bus.mem_we !== cap_we || bus.mem_addr !== cap_addr ||
                         bus.mem_be !== cap_be || bus.mem_wdata !== cap_wd) begin
               stable = 1'b0;
            end
            if (req_cnt == v.delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = v.rdata;
            end else begin
               bus.mem_ack   = 1'b0;
               bus.mem_rdata = $urandom;
            end
            req_cnt++;
         end else begin
            idle_ack();
         end
         if (done_cyc >= 0) break;
      end
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         if (bus.mem_req || done) quiet = 1'b0;
         idle_ack();
      end
      bus.mem_ack = 1'b0;

      check({name, " req_cycles"}, 32'(req_cnt), 32'(v.exp_req_cycles));
      if (v.exp_req_cycles > 0) begin
         check({name, " mem_we"},   32'(cap_we), 32'(v.exp_we));
         check({name, " mem_addr"}, cap_addr, v.exp_addr);
         check({name, " mem_be"},   32'(cap_be), 32'(v.exp_be));
         if (v.exp_we) check({name, " mem_wdata"}, cap_wd, v.exp_wdata);
         check({name, " bus_stable"}, 32'(stable), 32'd1);
      end
      check({name, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
      check({name, " misaligned"}, 32'(mis_d), 32'(v.exp_mis));
      check({name, " timeout"},    32'(to_d), 32'(v.exp_to));
      check({name, " read_value"}, rv_d, v.exp_rv);
      check({name, " busy_after_accept"}, 32'(busy1), 32'd1);
      check({name, " busy_at_done"}, 32'(busy_d), 32'd0);
      check({name, " quiet_after_done"}, 32'(quiet), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual running required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        no_done;
      vec_t        v;
      logic [2:0]  f3s [5];

      // rd, wr, raddr, waddr, wdata, f3, delay, rdata, poke,
      // exp_req_cycles, exp_we, exp_addr, exp_be, exp_wdata, exp_done, exp_mis, exp_to, exp_rv
      tbl[0]  = '{1'b0, 1'b1, 32'h0, 32'h1003, 32'h000000AB, 3'b000, 2, 32'h0, 1'b0,
                  3, 1'b1, 32'h1000, 4'b1000, 32'hABABABAB, 5, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 1'b0, 32'h2002, 32'h0, 32'h0, 3'b101, 0, 32'hBEEF1234, 1'b0,
                  1, 1'b0, 32'h2000, 4'b1100, 32'h0, 3, 1'b0, 1'b0, 32'h0000BEEF};
      tbl[2]  = '{1'b1, 1'b0, 32'h3001, 32'h0, 32'h0, 3'b010, 0, 32'h0, 1'b0,
                  0, 1'b0, 32'h0, 4'b0000, 32'h0, 2, 1'b1, 1'b0, 32'h0000BEEF};
      tbl[3]  = '{1'b1, 1'b0, 32'h4000, 32'h0, 32'h0, 3'b010, 99, 32'h0, 1'b0,
                  4, 1'b0, 32'h4000, 4'b1111, 32'h0, 6, 1'b0, 1'b1, 32'h0000BEEF};
      tbl[4]  = '{1'b1, 1'b0, 32'h4000, 32'h0, 32'h0, 3'b010, 3, 32'hCAFEF00D, 1'b0,
                  4, 1'b0, 32'h4000, 4'b1111, 32'h0, 6, 1'b0, 1'b0, 32'hCAFEF00D};
      tbl[5]  = '{1'b1, 1'b1, 32'h20, 32'h10, 32'h12345678, 3'b010, 1, 32'h0, 1'b1,
                  2, 1'b1, 32'h10, 4'b1111, 32'h12345678, 4, 1'b0, 1'b0, 32'hCAFEF00D};
      tbl[6]  = '{1'b1, 1'b0, 32'h5001, 32'h0, 32'h0, 3'b000, 0, 32'h11223344, 1'b0,
                  1, 1'b0, 32'h5000, 4'b0010, 32'h0, 3, 1'b0, 1'b0, 32'h00000033};
      tbl[7]  = '{1'b0, 1'b1, 32'h0, 32'h6002, 32'hFFFFA5C3, 3'b001, 1, 32'h0, 1'b0,
                  2, 1'b1, 32'h6000, 4'b1100, 32'hA5C3A5C3, 4, 1'b0, 1'b0, 32'h00000033};
      tbl[8]  = '{1'b0, 1'b1, 32'h0, 32'h6001, 32'h1234, 3'b001, 0, 32'h0, 1'b0,
                  0, 1'b0, 32'h0, 4'b0000, 32'h0, 2, 1'b1, 1'b0, 32'h00000033};
      tbl[9]  = '{1'b1, 1'b0, 32'h7000, 32'h0, 32'h0, 3'b001, 0, 32'h87654321, 1'b1,
                  1, 1'b0, 32'h7000, 4'b0011, 32'h0, 3, 1'b0, 1'b0, 32'h00004321};
      tbl[10] = '{1'b1, 1'b0, 32'h7003, 32'h0, 32'h0, 3'b100, 2, 32'h9A000000, 1'b0,
                  3, 1'b0, 32'h7000, 4'b1000, 32'h0, 5, 1'b0, 1'b0, 32'h0000009A};
      tbl[11] = '{1'b1, 1'b0, 32'h8002, 32'h0, 32'h0, 3'b010, 0, 32'h0, 1'b0,
                  0, 1'b0, 32'h0, 4'b0000, 32'h0, 2, 1'b1, 1'b0, 32'h0000009A};
      tbl[12] = '{1'b1, 1'b0, 32'h9004, 32'h0, 32'h0, 3'b010, 4, 32'h0, 1'b0,
                  4, 1'b0, 32'h9004, 4'b1111, 32'h0, 6, 1'b0, 1'b1, 32'h0000009A};

      reset             = 1'b1;
      req_read_en       = 1'b0;
      req_write_en      = 1'b0;
      req_read_address  = '0;
      req_write_address = '0;
      req_write_data    = '0;
      req_funct3        = '0;
      bus.mem_ack       = 1'b0;
      bus.mem_rdata     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset flags", 32'({busy, done, misaligned, timeout, bus.mem_req, bus.mem_we}), 32'd0);
      check("reset read_value", read_value, 32'h0);
      check("reset mem_addr", bus.mem_addr, 32'h0);
      check("reset mem_be", 32'(bus.mem_be), 32'h0);
      check("reset mem_wdata", bus.mem_wdata, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Reset while a load is waiting on memory.
      req_read_en      = 1'b1;
      req_read_address = 32'h9000;
      req_funct3       = SIZE_W;
      @(posedge clk); #1;
      req_read_en = 1'b0;
      check("rst_mid mem_req_before", 32'(bus.mem_req), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_mid mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_mid busy", 32'(busy), 32'd0);
      check("rst_mid read_value", read_value, 32'h0);
      no_done = ~done;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (done || bus.mem_req) no_done = 1'b0;
      end
      check("rst_mid no_done", 32'(no_done), 32'd1);
      v = '{1'b1, 1'b0, 32'hA000, 32'h0, 32'h0, 3'b010, 1, 32'h0BADC0DE, 1'b0,
            2, 1'b0, 32'hA000, 4'b1111, 32'h0, 4, 1'b0, 1'b0, 32'h0BADC0DE};
      apply(v, "post_reset_lw");
      model_rv = 32'h0BADC0DE;

      f3s = '{SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU};
      stray_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         v.wr    = 1'($urandom_range(0, 1));
         v.rd    = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
         v.raddr = $urandom;
         v.waddr = $urandom;
         v.wdata = $urandom;
         v.rdata = $urandom;
         v.f3    = f3s[$urandom_range(0, 4)];
         v.delay = $urandom_range(0, 5);
         v.poke  = 1'($urandom_range(0, 1));
         v = model(v, model_rv);
         apply(v, $sformatf("rnd%0d", i));
         model_rv = v.exp_rv;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
